// File: rtl/cnn_result_tx.sv
// -----------------------------------------------------------------------------
// cnn_result_tx
// Outbound half of the CNN UART link. Result bytes from cnn_core are buffered
// in a small FIFO and framed for the UART transmitter. Each frame is sent as
// HDR_BYTE, FRAME_LEN payload bytes and an 8-bit checksum of the payload.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset (pre-synchronised)
//   res_vld     core presents a result byte
//   res_data    result byte
//   res_rdy     FIFO can accept (push = res_vld & res_rdy)
//   trmt        one-cycle pulse: UART starts sending tx_data
//   tx_data     byte to transmit, stable until the matching tx_done
//   tx_done     one-cycle pulse from UART: current byte finished
//   busy        high whenever the framer is not idle
//   frame_done  one-cycle pulse after the checksum byte completes
// -----------------------------------------------------------------------------
module cnn_result_tx #(
    parameter int unsigned FRAME_LEN = 26,
    parameter int unsigned DEPTH     = 16,
    parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_vld,
    input  logic [7:0] res_data,
    output logic       res_rdy,
    output logic       trmt,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned LW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [LW-1:0] LEN      = LW'(FRAME_LEN);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SEL_HDR, SEL_PL, SEL_CSUM} sel_t;

    // ---------------- result FIFO ----------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign res_rdy = !full;
    // full is judged on the registered count, so a same-cycle pop never
    // opens room for a push at full
    assign push    = res_vld && !full;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= res_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- framing FSM ----------------
    state_t        state, state_nxt;
    sel_t          sel, sel_nxt;
    logic [LW-1:0] cnt, cnt_nxt;
    logic [7:0]    csum, csum_nxt;
    logic [7:0]    tx_data_nxt;
    logic          trmt_nxt;
    logic          frame_done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= SEL_HDR;
            cnt        <= '0;
            csum       <= '0;
            tx_data    <= '0;
            trmt       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            cnt        <= cnt_nxt;
            csum       <= csum_nxt;
            tx_data    <= tx_data_nxt;
            trmt       <= trmt_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!empty) state_nxt = WAIT;
            WAIT: if (tx_done) state_nxt = (sel == SEL_CSUM) ? DONE : LOAD;
            LOAD: if ((cnt == LEN) || !empty) state_nxt = WAIT;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_data_nxt    = tx_data;
        trmt_nxt       = 1'b0;
        frame_done_nxt = 1'b0;
        cnt_nxt        = cnt;
        csum_nxt       = csum;
        sel_nxt        = sel;
        pop            = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    tx_data_nxt = HDR_BYTE;
                    trmt_nxt    = 1'b1;
                    cnt_nxt     = '0;
                    csum_nxt    = '0;
                    sel_nxt     = SEL_HDR;
                end
            end
            LOAD: begin
                if (cnt == LEN) begin
                    tx_data_nxt = csum;
                    trmt_nxt    = 1'b1;
                    sel_nxt     = SEL_CSUM;
                end else if (!empty) begin
                    pop         = 1'b1;
                    tx_data_nxt = head;
                    csum_nxt    = csum + head;
                    cnt_nxt     = cnt + LW'(1);
                    trmt_nxt    = 1'b1;
                    sel_nxt     = SEL_PL;
                end
            end
            DONE: frame_done_nxt = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
